// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional overflow output is enabled by defining SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SERIAL_SUB_DEFAULT_WIDTH = 4;

    // Bit counter width; a one-bit floor keeps WIDTH=2 (and any degenerate value) legal.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: diff = a - b - b_in, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic b_out
);

    assign diff  = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = A - B - Bin, LSB first, one bit per clock, valid/ready on both sides.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             busy
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic             borrow;
    logic [CW-1:0]    count;

    logic             cell_diff;
    logic             cell_borrow;
    logic [WIDTH-1:0] partial;

    full_subtractor u_cell (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .b_in  (borrow),
        .diff  (cell_diff),
        .b_out (cell_borrow)
    );

    // New bit enters at the MSB so the finished word is aligned after WIDTH shifts.
    assign partial = {cell_diff, res_sh};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            borrow <= 1'b0;
            count  <= '0;
            D      <= '0;
            Bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        borrow <= Bin;
                        count  <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    res_sh <= partial[WIDTH-1:1];
                    borrow <= cell_borrow;
                    count  <= count + 1'b1;
                    // D/Bout only update here, so they hold the previous result through RUN.
                    if (count == LAST_BIT) begin
                        D     <= partial;
                        Bout  <= cell_borrow;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= (a_sh[0] != b_sh[0]) && (cell_diff != a_sh[0]);
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
